// File: rtl/md_pkg.sv
// Shared definitions for the multiply/divide unit: operation codes,
// controller state encoding and default latencies.
package md_pkg;

    // md_op encodings carried with start
    localparam logic [2:0] MD_MULT  = 3'd1;
    localparam logic [2:0] MD_MULTU = 3'd2;
    localparam logic [2:0] MD_DIV   = 3'd3;
    localparam logic [2:0] MD_DIVU  = 3'd4;
    localparam logic [2:0] MD_MTHI  = 3'd5;
    localparam logic [2:0] MD_MTLO  = 3'd6;

    // Default busy periods in cycles
    localparam int MD_MULT_LAT_DEF = 5;
    localparam int MD_DIV_LAT_DEF  = 10;

    // Controller states
    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } md_state_e;

endpackage

// File: rtl/md_if.sv
// E-stage request/status bundle between the pipeline and the md unit.
// Handshake: start is a one-cycle request qualified by busy; a start seen
// while busy is high is not accepted and has no effect. md_op, rs_val and
// rt_val are only meaningful in the cycle start is high.
interface md_if;
    import md_pkg::*;

    logic        start;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        md_use_d;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    md_state_e   dbg_state;

    // Pipeline side
    modport master (
        output start, md_op, rs_val, rt_val, md_use_d,
        input  busy, stall, hi, lo, dbg_state
    );

    // md unit side
    modport slave (
        input  start, md_op, rs_val, rt_val, md_use_d,
        output busy, stall, hi, lo, dbg_state
    );

endinterface

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath working on the latched operands.
// Produces the {hi,lo} result and a keep flag for divide by zero.
module md_arith
    import md_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [63:0] result,
    output logic        keep
);

    logic [63:0] prod_u;
    logic [63:0] prod_s;
    logic [31:0] div_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic [31:0] uq;
    logic [31:0] ur;
    logic [31:0] sq;
    logic [31:0] sr;

    // Signed results are built from magnitudes so 0x80000000 / -1 wraps
    // naturally to lo=0x80000000, hi=0 without a special case.
    always_comb begin
        prod_u = {32'd0, a} * {32'd0, b};
        // Low 64 bits of the sign-extended product equal the signed product.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        div_b  = (b == 32'd0) ? 32'd1 : b;
        uq     = a / div_b;
        ur     = a % div_b;
        mag_a  = a[31] ? (~a + 32'd1) : a;
        mag_b  = b[31] ? (~b + 32'd1) : b;
        if (mag_b == 32'd0) begin
            mag_b = 32'd1;
        end
        sq     = mag_a / mag_b;
        sr     = mag_a % mag_b;
        if (a[31] ^ b[31]) begin
            sq = ~sq + 32'd1;
        end
        if (a[31]) begin
            sr = ~sr + 32'd1;
        end
        keep   = 1'b0;
        result = 64'd0;
        case (op)
            MD_MULT:  result = prod_s;
            MD_MULTU: result = prod_u;
            MD_DIV: begin
                result = {sr, sq};
                keep   = (b == 32'd0);
            end
            MD_DIVU: begin
                result = {ur, uq};
                keep   = (b == 32'd0);
            end
            default:  result = 64'd0;
        endcase
    end

endmodule

// File: rtl/md_ctrl.sv
// Multiply/divide controller: owns HI/LO, sequences multi-cycle operations
// with a latency counter, applies MTHI/MTLO directly and requests F/D stalls.
module md_ctrl
    import md_pkg::*;
#(
    parameter int MULT_LAT = MD_MULT_LAT_DEF,
    parameter int DIV_LAT  = MD_DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    md_if.slave  bus
);

    localparam int MAX_LAT = (MULT_LAT > DIV_LAT) ? MULT_LAT : DIV_LAT;
    localparam int CNT_W   = $clog2(MAX_LAT + 1);

    md_state_e          state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2:0]         op_q, op_d;
    logic [31:0]        rs_q, rs_d;
    logic [31:0]        rt_q, rt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    logic               busy_q, busy_d;

    logic [63:0]        arith_res;
    logic               arith_keep;

    md_arith u_arith (
        .op     (op_q),
        .a      (rs_q),
        .b      (rt_q),
        .result (arith_res),
        .keep   (arith_keep)
    );

    // Next-state logic: accept work in IDLE, count down in BUSY and commit
    // the result on the edge where the counter reaches zero.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        rs_d    = rs_q;
        rt_d    = rt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        busy_d  = busy_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    case (bus.md_op)
                        MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
                            op_d    = bus.md_op;
                            rs_d    = bus.rs_val;
                            rt_d    = bus.rt_val;
                            cnt_d   = ((bus.md_op == MD_MULT) || (bus.md_op == MD_MULTU))
                                      ? CNT_W'(MULT_LAT) : CNT_W'(DIV_LAT);
                            busy_d  = 1'b1;
                            state_d = ST_BUSY;
                        end
                        MD_MTHI: hi_d = bus.rs_val;
                        MD_MTLO: lo_d = bus.rs_val;
                        default: ;
                    endcase
                end
            end
            ST_BUSY: begin
                // A start arriving here is a protocol violation and is dropped.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                    if (!arith_keep) begin
                        hi_d = arith_res[63:32];
                        lo_d = arith_res[31:0];
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    // State register; reset discards any pending result.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= 3'd0;
            rs_q    <= 32'd0;
            rt_q    <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            rs_q    <= rs_d;
            rt_q    <= rt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
        end
    end

    // Stall has zero latency so a D-stage HI/LO user is held the same cycle.
    assign bus.stall     = bus.md_use_d & (busy_q | bus.start);
    assign bus.busy      = busy_q;
    assign bus.hi        = hi_q;
    assign bus.lo        = lo_q;
    assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_md_ctrl.sv
// Directed bench for md_ctrl: HI/LO arithmetic, latency, stall and reset.
module tb_md_ctrl;
    import md_pkg::*;

    logic clk;
    logic reset;
    int   total;
    int   bad;

    md_if bus ();

    md_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver: issue one start at a negedge, then count busy cycles and
    // stall errors until busy falls. Returns just after that negedge.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic use_d, output int ncyc, output int stall_err);
        ncyc = 0;
        stall_err = 0;
        bus.start = 1'b1;
        bus.md_op = op;
        bus.rs_val = a;
        bus.rt_val = b;
        bus.md_use_d = use_d;
        #1;
        if (bus.stall !== use_d) stall_err++;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        #1;
        while (bus.busy === 1'b1 && ncyc < 60) begin
            ncyc++;
            if (bus.stall !== use_d) stall_err++;
            @(negedge clk);
            #1;
        end
        if (bus.stall !== 1'b0) stall_err++;
        bus.md_use_d = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.hi !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", bus.hi); end
        total++; if (bus.lo !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", bus.lo); end
        total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        total++; if (bus.stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", bus.stall); end
        reset = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL post_reset got hi=%h lo=%h busy=%b exp 0/0/0", bus.hi, bus.lo, bus.busy); end
        total++; if (bus.dbg_state !== ST_IDLE) begin bad++; $display("FAIL post_reset_state got=%0d exp=IDLE", bus.dbg_state); end
    endtask

    task automatic test_mult();
        int n;
        int se;
        @(negedge clk);
        run_op(MD_MULT, 32'hFFFFFFFF, 32'd2, 1'b1, n, se);
        total++; if (n != 5) begin bad++; $display("FAIL mult_busy_len got=%0d exp=5", n); end
        total++; if (se != 0) begin bad++; $display("FAIL mult_stall errs got=%0d exp=0", se); end
        total++; if (bus.hi !== 32'hFFFFFFFF || bus.lo !== 32'hFFFFFFFE)
            begin bad++; $display("FAIL mult_res got=%h_%h exp=ffffffff_fffffffe", bus.hi, bus.lo); end
        run_op(MD_MULTU, 32'hFFFFFFFF, 32'd2, 1'b0, n, se);
        total++; if (n != 5) begin bad++; $display("FAIL multu_busy_len got=%0d exp=5", n); end
        total++; if (se != 0) begin bad++; $display("FAIL multu_stall_nouse errs got=%0d exp=0", se); end
        total++; if (bus.hi !== 32'h00000001 || bus.lo !== 32'hFFFFFFFE)
            begin bad++; $display("FAIL multu_res got=%h_%h exp=00000001_fffffffe", bus.hi, bus.lo); end
    endtask

    task automatic test_div();
        int n;
        int se;
        logic [31:0] va [6][2];
        logic [31:0] ex [6][2];
        logic [2:0]  op [6];
        // {op, rs, rt} -> {hi, lo}; the divide-by-zero row keeps the prior result
        op[0] = MD_DIVU; va[0] = '{32'd7, 32'd2};               ex[0] = '{32'd1, 32'd3};
        op[1] = MD_DIV;  va[1] = '{32'hFFFFFFF9, 32'd2};        ex[1] = '{32'hFFFFFFFF, 32'hFFFFFFFD};
        op[2] = MD_DIV;  va[2] = '{32'd5, 32'd0};               ex[2] = '{32'hFFFFFFFF, 32'hFFFFFFFD};
        op[3] = MD_DIV;  va[3] = '{32'h80000000, 32'hFFFFFFFF}; ex[3] = '{32'd0, 32'h80000000};
        op[4] = MD_DIV;  va[4] = '{32'd7, 32'hFFFFFFFE};        ex[4] = '{32'd1, 32'hFFFFFFFD};
        op[5] = MD_DIVU; va[5] = '{32'hFFFFFFFF, 32'h10};       ex[5] = '{32'hF, 32'h0FFFFFFF};
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
            run_op(op[i], va[i][0], va[i][1], 1'b1, n, se);
            total++; if (n != 10) begin bad++; $display("FAIL div%0d_busy_len got=%0d exp=10", i, n); end
            total++; if (se != 0) begin bad++; $display("FAIL div%0d_stall errs got=%0d exp=0", i, se); end
            total++; if (bus.hi !== ex[i][0] || bus.lo !== ex[i][1])
                begin bad++; $display("FAIL div%0d_res got=%h_%h exp=%h_%h", i, bus.hi, bus.lo, ex[i][0], ex[i][1]); end
        end
    endtask

    task automatic test_mthi_mtlo();
        int n;
        int se;
        @(negedge clk);
        run_op(MD_MTHI, 32'h1234, 32'd0, 1'b0, n, se);
        total++; if (n != 0) begin bad++; $display("FAIL mthi_busy got=%0d exp=0", n); end
        total++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h0FFFFFFF)
            begin bad++; $display("FAIL mthi_res got=%h_%h exp=00001234_0fffffff", bus.hi, bus.lo); end
        run_op(MD_MTLO, 32'h5678, 32'd0, 1'b1, n, se);
        total++; if (n != 0 || se != 0) begin bad++; $display("FAIL mtlo_busy got=%0d/%0d exp=0/0", n, se); end
        total++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h5678)
            begin bad++; $display("FAIL mtlo_res got=%h_%h exp=00001234_00005678", bus.hi, bus.lo); end
        run_op(3'd7, 32'hAAAA, 32'hBBBB, 1'b0, n, se);
        total++; if (n != 0 || bus.hi !== 32'h1234 || bus.lo !== 32'h5678)
            begin bad++; $display("FAIL undef_op got busy=%0d %h_%h exp=0 00001234_00005678", n, bus.hi, bus.lo); end
    endtask

    task automatic test_ignore_busy();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = MD_MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = MD_MTLO; bus.rs_val = 32'hDEAD;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        #1;
        total++; if (bus.lo !== 32'h5678 || bus.busy !== 1'b1)
            begin bad++; $display("FAIL mtlo_in_busy got lo=%h busy=%b exp=00005678/1", bus.lo, bus.busy); end
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin @(negedge clk); #1; n++; end
        total++; if (n != 3) begin bad++; $display("FAIL busy_remaining got=%0d exp=3", n); end
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd12)
            begin bad++; $display("FAIL mult_after_ignore got=%h_%h exp=00000000_0000000c", bus.hi, bus.lo); end
    endtask

    task automatic test_back_to_back();
        int n;
        @(negedge clk);
        bus.start = 1'b1; bus.md_op = MD_MULTU; bus.rs_val = 32'd5; bus.rt_val = 32'd6; bus.md_use_d = 1'b1;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        #1;
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin @(negedge clk); #1; n++; end
        total++; if (n != 5 || bus.lo !== 32'd30) begin bad++; $display("FAIL b2b_first got len=%0d lo=%h exp=5/0000001e", n, bus.lo); end
        // New start in the first cycle busy is low
        bus.start = 1'b1; bus.md_op = MD_MULTU; bus.rs_val = 32'd7; bus.rt_val = 32'd8;
        #1;
        total++; if (bus.stall !== 1'b1) begin bad++; $display("FAIL b2b_stall got=%b exp=1", bus.stall); end
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b1 || bus.stall !== 1'b1)
            begin bad++; $display("FAIL b2b_accept got busy=%b stall=%b exp=1/1", bus.busy, bus.stall); end
        n = 0;
        while (bus.busy === 1'b1 && n < 60) begin @(negedge clk); #1; n++; end
        total++; if (n != 5 || bus.hi !== 32'd0 || bus.lo !== 32'd56 || bus.stall !== 1'b0)
            begin bad++; $display("FAIL b2b_second got len=%0d %h_%h stall=%b exp=5 0_00000038 0", n, bus.hi, bus.lo, bus.stall); end
        bus.md_use_d = 1'b0;
    endtask

    task automatic test_reset_mid();
        int n;
        int se;
        @(negedge clk);
        run_op(MD_MTHI, 32'hCAFE, 32'd0, 1'b0, n, se);
        bus.start = 1'b1; bus.md_op = MD_DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd7;
        @(posedge clk); @(negedge clk);
        bus.start = 1'b0;
        bus.md_use_d = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        #1;
        total++; if (bus.busy !== 1'b0 || bus.stall !== 1'b0)
            begin bad++; $display("FAIL rst_mid_busy got busy=%b stall=%b exp=0/0", bus.busy, bus.stall); end
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0)
            begin bad++; $display("FAIL rst_mid_hilo got=%h_%h exp=0_0", bus.hi, bus.lo); end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        bus.md_use_d = 1'b0;
        repeat (15) @(negedge clk);
        #1;
        total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.busy !== 1'b0)
            begin bad++; $display("FAIL rst_mid_after got %h_%h busy=%b exp=0_0 0", bus.hi, bus.lo, bus.busy); end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset = 1'b0;
        bus.start = 1'b0;
        bus.md_op = 3'd0;
        bus.rs_val = 32'd0;
        bus.rt_val = 32'd0;
        bus.md_use_d = 1'b0;
        test_reset();
        test_mult();
        test_div();
        test_mthi_mtlo();
        test_ignore_busy();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Overall time limit so the run always ends
    initial begin
        #200000;
        $display("FAIL timeout reached before test end");
        $fatal(1);
    end

endmodule

// File: doc/md_ctrl.md
# md_ctrl

Multiply/divide unit controller for the five-stage MIPS pipeline. Sits in the E stage beside the ALU and owns the HI/LO registers. Sequences multi-cycle MULT/MULTU/DIV/DIVU operations with a latency counter, handles immediate MTHI/MTLO writes, and raises the stall request that freezes the F/D stages while a D-stage instruction needs HI/LO and the unit is occupied.

## Interface
- MULT_LAT, 5, busy cycles for MULT/MULTU (≥1)
- DIV_LAT, 10, busy cycles for DIV/DIVU (≥1)
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-low; low clears all state immediately
- start  in  1  one-cycle pulse, E-stage instruction is an md operation
- md_op  in  3  operation code, md_pkg encoding, valid with start
- rs_val  in  32  forwarded rs operand, valid with start
- rt_val  in  32  forwarded rt operand, valid with start
- md_use_d  in  1  D-stage instruction is mult/div/mfhi/mflo/mthi/mtlo
- busy  out  1  multi-cycle operation in progress
- stall  out  1  stall request to hazard logic
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. Reset → IDLE, cnt=0, hi=0, lo=0, busy=0, stall=0.
- IDLE + start + md_op∈{MULT,MULTU,DIV,DIVU}: latch md_op, rs_val, rt_val; load cnt with MULT_LAT or DIV_LAT; → BUSY.
- IDLE + start + MTHI: hi←rs_val at that edge; MTLO: lo←rs_val; stay IDLE, busy never asserts.
- BUSY: cnt decrements each edge; on the edge where cnt reaches 0, write hi/lo from latched operands, → IDLE.
- start while BUSY: protocol violation, ignored (no latch, no HI/LO change).
- Undefined md_op with start: ignored.
- stall = md_use_d & (busy | start), combinational.
- Arithmetic (32×32→64): MULT signed, MULTU unsigned; hi=product[63:32], lo=product[31:0].
- DIV signed: lo=quotient truncated toward zero, hi=remainder with dividend's sign; DIVU unsigned.
- Divide by zero: full DIV_LAT busy period, hi/lo unchanged.
- Signed overflow 0x80000000/−1: lo=0x80000000, hi=0.

## Timing
- start sampled at edge E0. busy high from E0 through edge E(N), N = lat; high for exactly N cycles.
- hi/lo update and busy fall at the same edge E(N); new values readable in the cycle busy is low.
- MTHI/MTLO: hi/lo visible one cycle after start, zero busy cycles.
- Back-to-back: start accepted in the first cycle busy is low.
- stall has zero latency; drops in the cycle busy falls, unless start is high then.
- reset low mid-operation: immediately IDLE, busy=0, hi=lo=0, pending result discarded.
- cnt width = $clog2(max(MULT_LAT, DIV_LAT)+1).

## Structure
- md_pkg: md_op encodings (MD_MULT=1, MD_MULTU=2, MD_DIV=3, MD_DIVU=4, MD_MTHI=5, MD_MTLO=6), state encoding, default latencies.
- Sub-module md_arith: combinational; latched op/operands in, 64-bit {hi,lo} result out, including div-by-zero keep flag. Controller holds FSM, counter, HI/LO, stall.

## Test plan
- Reset low for 2 cycles → hi=0, lo=0, busy=0, stall=0; release → unchanged.
- MULT rs=0xFFFFFFFF, rt=2 → busy high exactly 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFE; MULTU same operands → hi=0x00000001, lo=0xFFFFFFFE.
- DIVU 7/2 → after 10 cycles lo=3, hi=1; DIV 0xFFFFFFF9/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV x/0 → hi/lo unchanged, busy 10 cycles.
- md_use_d high during start cycle and all busy cycles → stall high throughout, low in first cycle busy=0; md_use_d low → stall never high.
- MTHI rs=0x1234 → hi=0x1234 next cycle, busy stays 0; start with MTLO during MULT busy → ignored, lo gets only product.
- reset low during cycle 3 of a DIV → busy=0, hi=lo=0 before next edge; no write occurs after release.
